// File: rtl/mips_prog_loader.sv
// Streams a program into core memory with the core held in reset, runs it, then reads back one result word.
// Latency: one word per beat, result_valid 3 cycles after halt; in_valid gaps stall LOAD, start outside IDLE is dropped.
module mips_prog_loader #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int CYCLE_LIMIT = 4096
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] result_addr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_rst,
  input  logic              core_halted,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  output logic              timeout
);

  localparam int CW = $clog2(CYCLE_LIMIT);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, READ, WAIT_RD, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   last_idx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [CW-1:0]     cyc;
  logic              beat;
  logic              halt_go;
  logic              limit_go;

  assign last_idx = len_q - {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clk1) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    beat         = 1'b0;
    halt_go      = 1'b0;
    limit_go     = 1'b0;
    in_ready     = 1'b0;
    mem_re       = 1'b0;
    core_rst     = 1'b1;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = (prog_len == '0) ? RUN : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          beat = 1'b1;
          if (count == last_idx) state_n = RUN;
        end
      end
      RUN: begin
        core_rst = 1'b0;
        // the first two RUN cycles may still show HALTED left over from the previous program
        halt_go  = core_halted && (cyc >= CW'(2));
        limit_go = !halt_go && (cyc == CW'(CYCLE_LIMIT - 1));
        if (halt_go)       state_n = READ;
        else if (limit_go) state_n = DONE;
      end
      READ: begin
        mem_re  = 1'b1;
        state_n = WAIT_RD;
      end
      WAIT_RD: state_n = DONE;
      DONE: begin
        result_valid = 1'b1;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      len_q       <= '0;
      count       <= '0;
      base_q      <= '0;
      raddr_q     <= '0;
      cyc         <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      result_data <= '0;
      timeout     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q   <= prog_len;
            base_q  <= base_addr;
            raddr_q <= result_addr;
            count   <= '0;
            cyc     <= '0;
            timeout <= 1'b0;
          end
        end
        LOAD: begin
          if (beat) begin
            mem_we    <= 1'b1;
            mem_addr  <= base_q + count[ADDR_W-1:0];
            mem_wdata <= in_data;
            count     <= count + 1'b1;
          end
        end
        RUN: begin
          cyc <= cyc + 1'b1;
          // result address is presented during the single READ cycle that follows
          if (halt_go) mem_addr <= raddr_q;
          else if (limit_go) begin
            timeout     <= 1'b1;
            result_data <= '0;
          end
        end
        WAIT_RD: result_data <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule
